// File: rtl/lc3_control_if.sv
// Controller <-> datapath bundle for the LC-3 control unit.
// The master drives the control word; the slave supplies the IR fields and BEN.
interface lc3_control_if;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_IR;
    logic       LD_BEN;
    logic       LD_CC;
    logic       LD_REG;
    logic       LD_PC;
    logic       LD_LED;

    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;

    logic [1:0] PCMUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       SR1MUX;
    logic       SR2MUX;
    logic       DRMUX;
    logic       ADDR1MUX;

    logic       MIO_EN;
    logic       Mem_OE;
    logic       Mem_WE;

    modport master (
        input  Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN,
        output LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ALUK,
        output SR1MUX, SR2MUX, DRMUX, ADDR1MUX,
        output MIO_EN, Mem_OE, Mem_WE
    );

    modport slave (
        output Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN,
        input  LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ALUK,
        input  SR1MUX, SR2MUX, DRMUX, ADDR1MUX,
        input  MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_control.sv
// LC-3 Moore control FSM: fetch/decode/execute with stretched memory states
// and a PSE pause that steps one instruction per Continue press.
module lc3_control #(
    parameter int MEM_WAIT = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Run,
    input  logic           Continue,
    lc3_control_if.master  bus
);
    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S1, S5, S9, S0, S22,
        S12, S4, S21, S20, S6,
        S25, S27, S7, S23, S16,
        PAUSE1, PAUSE2
    } state_t;

    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    state_t     state;
    state_t     next;
    logic [2:0] cnt;
    logic [2:0] cnt_n;
    logic       mem_state;
    logic       mem_last;

    assign mem_state = (state == S33) || (state == S25) || (state == S16);
    assign mem_last  = (cnt == LAST);

    // Counter only runs inside a memory state, so it is zero on every entry.
    assign cnt_n = (mem_state && !mem_last) ? cnt + 3'd1 : 3'd0;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= HALTED;
            cnt   <= 3'd0;
        end else begin
            state <= next;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        next           = state;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.DRMUX      = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;

        unique case (state)
            HALTED: if (Run) next = S18;
            S18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                next       = S33;
            end
            S33, S25: begin
                bus.Mem_OE = 1'b0;
                bus.MIO_EN = 1'b1;
                if (mem_last) begin
                    bus.LD_MDR = 1'b1;
                    next       = (state == S33) ? S35 : S27;
                end
            end
            S35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                next        = S32;
            end
            S32: begin
                bus.LD_BEN = 1'b1;
                unique case (bus.Opcode)
                    4'b0001: next = S1;
                    4'b0101: next = S5;
                    4'b1001: next = S9;
                    4'b0000: next = S0;
                    4'b1100: next = S12;
                    4'b0100: next = S4;
                    4'b0110: next = S6;
                    4'b0111: next = S7;
                    4'b1101: next = PAUSE1;
                    default: next = S18;
                endcase
            end
            S1, S5, S9: begin
                bus.SR1MUX  = 1'b1;
                bus.SR2MUX  = bus.IR_5;
                bus.ALUK    = (state == S1) ? 2'b00 :
                              (state == S5) ? 2'b01 : 2'b10;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                next        = S18;
            end
            S0: next = bus.BEN ? S22 : S18;
            S22, S21: begin
                bus.ADDR2MUX = (state == S22) ? 2'b10 : 2'b11;
                bus.PCMUX    = 2'b10;
                bus.LD_PC    = 1'b1;
                next         = S18;
            end
            S12, S20: begin
                bus.SR1MUX   = 1'b1;
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = 2'b10;
                bus.LD_PC    = 1'b1;
                next         = S18;
            end
            S4: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
                next       = bus.IR_11 ? S21 : S20;
            end
            S6, S7: begin
                bus.SR1MUX     = 1'b1;
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                next           = (state == S6) ? S25 : S23;
            end
            S27: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                next        = S18;
            end
            S23: begin
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                next        = S16;
            end
            S16: begin
                bus.Mem_WE = 1'b0;
                if (mem_last) next = S18;
            end
            PAUSE1: begin
                bus.LD_LED = 1'b1;
                if (Continue) next = PAUSE2;
            end
            PAUSE2: if (!Continue) next = S18;
            default: next = HALTED;
        endcase
    end
endmodule

// File: tb/tb_lc3_control.sv
// Bench for lc3_control: instruction table plus hand-built reset/pause
// sequences, with expected control words queued and compared every cycle.
module tb_lc3_control;
    localparam int MW = 2;

    typedef enum int {
        T_HALT, T_S18, T_S33, T_S35, T_S32, T_S1, T_S5, T_S9,
        T_S0, T_S22, T_S12, T_S4, T_S21, T_S20, T_S6, T_S25,
        T_S27, T_S7, T_S23, T_S16, T_P1, T_P2
    } tst_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben;
        logic       ld_cc, ld_reg, ld_pc, ld_led;
        logic       g_pc, g_mdr, g_alu, g_mar;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       sr1mux, sr2mux, drmux, addr1mux;
        logic       mio_en, mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       ir5, ir11, ben, run, cont;
        int         n;
        tst_t       p0, p1, p2, p3;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    logic Run;
    logic Continue;
    lc3_control_if bus ();

    lc3_control #(.MEM_WAIT(MW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Continue (Continue),
        .bus      (bus)
    );

    always #5 Clk = ~Clk;

    ctl_t act;
    always_comb act = {
        bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN,
        bus.LD_CC, bus.LD_REG, bus.LD_PC, bus.LD_LED,
        bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
        bus.PCMUX, bus.ADDR2MUX, bus.ALUK,
        bus.SR1MUX, bus.SR2MUX, bus.DRMUX, bus.ADDR1MUX,
        bus.MIO_EN, bus.Mem_OE, bus.Mem_WE
    };

    int   checks = 0;
    int   errors = 0;
    ctl_t sb[$];
    vec_t vecs[$];

    function automatic ctl_t exp_word(tst_t s, logic ir5, logic last);
        ctl_t d = '0;
        d.mem_oe = 1'b1;
        d.mem_we = 1'b1;
        case (s)
            T_S18: begin d.g_pc = 1; d.ld_mar = 1; d.ld_pc = 1; end
            T_S33, T_S25: begin
                d.mem_oe = 0; d.mio_en = 1; d.ld_mdr = last;
            end
            T_S35: begin d.g_mdr = 1; d.ld_ir = 1; end
            T_S32: d.ld_ben = 1;
            T_S1, T_S5, T_S9: begin
                d.sr1mux = 1; d.sr2mux = ir5; d.g_alu = 1;
                d.ld_reg = 1; d.ld_cc = 1;
                d.aluk = (s == T_S1) ? 2'b00 : (s == T_S5) ? 2'b01 : 2'b10;
            end
            T_S22: begin d.addr2mux = 2'b10; d.pcmux = 2'b10; d.ld_pc = 1; end
            T_S21: begin d.addr2mux = 2'b11; d.pcmux = 2'b10; d.ld_pc = 1; end
            T_S12, T_S20: begin
                d.sr1mux = 1; d.addr1mux = 1; d.pcmux = 2'b10; d.ld_pc = 1;
            end
            T_S4: begin d.g_pc = 1; d.drmux = 1; d.ld_reg = 1; end
            T_S6, T_S7: begin
                d.sr1mux = 1; d.addr1mux = 1; d.addr2mux = 2'b01;
                d.g_mar = 1; d.ld_mar = 1;
            end
            T_S27: begin d.g_mdr = 1; d.ld_reg = 1; d.ld_cc = 1; end
            T_S23: begin d.aluk = 2'b11; d.g_alu = 1; d.ld_mdr = 1; end
            T_S16: d.mem_we = 0;
            T_P1: d.ld_led = 1;
            default: ;
        endcase
        return d;
    endfunction

    task automatic push(tst_t s, logic ir5);
        if (s == T_S33 || s == T_S25 || s == T_S16)
            for (int k = 0; k < MW; k++)
                sb.push_back(exp_word(s, ir5, k == MW - 1));
        else
            sb.push_back(exp_word(s, ir5, 1'b0));
    endtask

    task automatic push_fetch(logic ir5);
        push(T_S18, ir5);
        push(T_S33, ir5);
        push(T_S35, ir5);
        push(T_S32, ir5);
    endtask

    task automatic drain(string tag);
        ctl_t e;
        int   cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cyc%0d got=%h exp=%h", tag, cyc, act, e);
            end
            checks++;
            if ($countones({act.g_pc, act.g_mdr, act.g_alu, act.g_mar}) > 1) begin
                errors++;
                $display("FAIL %s_gates cyc%0d got=%h exp=onehot0", tag, cyc, act);
            end
            cyc++;
            @(negedge Clk);
        end
    endtask

    task automatic add(string nm, logic [3:0] op, logic i5, logic i11,
                       logic b, logic r, logic c, int n,
                       tst_t a0, tst_t a1, tst_t a2, tst_t a3);
        vec_t v;
        v.name = nm; v.op = op; v.ir5 = i5; v.ir11 = i11; v.ben = b;
        v.run = r; v.cont = c; v.n = n;
        v.p0 = a0; v.p1 = a1; v.p2 = a2; v.p3 = a3;
        vecs.push_back(v);
    endtask

    task automatic run_vec(vec_t v);
        bus.Opcode = v.op; bus.IR_5 = v.ir5; bus.IR_11 = v.ir11;
        bus.BEN = v.ben; Run = v.run; Continue = v.cont;
        push_fetch(v.ir5);
        if (v.n > 0) push(v.p0, v.ir5);
        if (v.n > 1) push(v.p1, v.ir5);
        if (v.n > 2) push(v.p2, v.ir5);
        if (v.n > 3) push(v.p3, v.ir5);
        drain(v.name);
    endtask

    initial begin
        add("add_imm",   4'b0001, 1, 0, 0, 1, 1, 1, T_S1,  T_HALT, T_HALT, T_HALT);
        add("and_reg",   4'b0101, 0, 0, 0, 0, 0, 1, T_S5,  T_HALT, T_HALT, T_HALT);
        add("not",       4'b1001, 1, 0, 1, 0, 0, 1, T_S9,  T_HALT, T_HALT, T_HALT);
        add("br_nt",     4'b0000, 0, 0, 0, 0, 0, 1, T_S0,  T_HALT, T_HALT, T_HALT);
        add("br_t",      4'b0000, 0, 0, 1, 0, 0, 2, T_S0,  T_S22,  T_HALT, T_HALT);
        add("jmp",       4'b1100, 0, 0, 0, 0, 0, 1, T_S12, T_HALT, T_HALT, T_HALT);
        add("jsr",       4'b0100, 0, 1, 0, 0, 0, 2, T_S4,  T_S21,  T_HALT, T_HALT);
        add("jsrr",      4'b0100, 0, 0, 0, 0, 0, 2, T_S4,  T_S20,  T_HALT, T_HALT);
        add("ldr",       4'b0110, 0, 0, 0, 0, 0, 3, T_S6,  T_S25,  T_S27,  T_HALT);
        add("str",       4'b0111, 0, 0, 0, 0, 0, 3, T_S7,  T_S23,  T_S16,  T_HALT);
        add("nop_1010",  4'b1010, 0, 0, 0, 0, 1, 0, T_HALT, T_HALT, T_HALT, T_HALT);

        Reset = 1'b0; Run = 1'b1; Continue = 1'b1;
        bus.Opcode = 4'b0001; bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
        @(negedge Clk);
        push(T_HALT, 0); push(T_HALT, 0);
        drain("reset_hold");
        Reset = 1'b1;
        push(T_HALT, 0);
        drain("reset_release");

        foreach (vecs[i]) run_vec(vecs[i]);

        bus.Opcode = 4'b1101; Continue = 1'b0; Run = 1'b0;
        push_fetch(0);
        for (int k = 0; k < 10; k++) push(T_P1, 0);
        drain("pse_wait");
        Continue = 1'b1;
        push(T_P1, 0); push(T_P2, 0); push(T_P2, 0);
        drain("pse_press");
        Continue = 1'b0;
        bus.Opcode = 4'b1010;
        push(T_P2, 0);
        push_fetch(0);
        drain("pse_step");

        bus.Opcode = 4'b0111;
        push_fetch(0); push(T_S7, 0); push(T_S23, 0);
        sb.push_back(exp_word(T_S16, 0, 0));
        drain("str_pre_rst");
        Reset = 1'b0; Run = 1'b1;
        sb.push_back(exp_word(T_S16, 0, 1));
        push(T_HALT, 0); push(T_HALT, 0);
        drain("rst_in_s16");
        Reset = 1'b1;
        push(T_HALT, 0);
        drain("restart1");
        Run = 1'b0;

        bus.Opcode = 4'b0001;
        sb.push_back(exp_word(T_S18, 0, 0));
        sb.push_back(exp_word(T_S33, 0, 0));
        drain("fetch_pre_rst");
        Reset = 1'b0;
        sb.push_back(exp_word(T_S33, 0, 1));
        push(T_HALT, 0);
        drain("rst_in_s33");
        Reset = 1'b1; Run = 1'b1;
        push(T_HALT, 0);
        drain("restart2");
        run_vec(vecs[0]);
        push(T_S18, 0);
        drain("final_s18");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
